// File: rtl/logic_arb_pkg.sv
// Shared encodings for the logic-unit arbiter: op codes, FSM states, perf counter width.
package logic_arb_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int PERF_CNT_W = 16;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise logic op (AND/OR/XOR/NOR) with per-operand inversion bubbles.
module logic_op_core
    import logic_arb_pkg::*;
#(
    parameter int NrOfBits = 32
) (
    input  logic [1:0]          inv,
    input  logic [1:0]          op,
    input  logic [NrOfBits-1:0] a,
    input  logic [NrOfBits-1:0] b,
    output logic [NrOfBits-1:0] y
);

    logic [NrOfBits-1:0] a_m;
    logic [NrOfBits-1:0] b_m;

    always_comb begin
        a_m = a ^ {NrOfBits{inv[0]}};
        b_m = b ^ {NrOfBits{inv[1]}};
        y   = '0;
        case (op)
            LOGIC_AND: y = a_m & b_m;
            LOGIC_OR:  y = a_m | b_m;
            LOGIC_XOR: y = a_m ^ b_m;
            default:   y = ~(a_m | b_m);
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one registered logic unit between two requesters, one-entry result buffer.
// Optional LOGIC_ARB_PERF_EN adds saturating grant/stall counters.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int NrOfBits = 32
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  Req0_Valid,
    output logic                  Req0_Ready,
    input  logic [1:0]            Req0_Op,
    input  logic [1:0]            Req0_Inv,
    input  logic [NrOfBits-1:0]   Req0_A,
    input  logic [NrOfBits-1:0]   Req0_B,
    input  logic                  Req1_Valid,
    output logic                  Req1_Ready,
    input  logic [1:0]            Req1_Op,
    input  logic [1:0]            Req1_Inv,
    input  logic [NrOfBits-1:0]   Req1_A,
    input  logic [NrOfBits-1:0]   Req1_B,
    output logic                  Rsp0_Valid,
    input  logic                  Rsp0_Ready,
    output logic                  Rsp1_Valid,
    input  logic                  Rsp1_Ready,
`ifdef LOGIC_ARB_PERF_EN
    output logic [PERF_CNT_W-1:0] Grant0_Cnt,
    output logic [PERF_CNT_W-1:0] Grant1_Cnt,
    output logic [PERF_CNT_W-1:0] Stall_Cnt,
`endif
    output logic [NrOfBits-1:0]   Rsp_Data
);

    logic [0:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [NrOfBits-1:0] data_q, data_d;

    logic                owner_rdy;
    logic                issue_ok;
    logic                any_vld;
    logic                grant1;
    logic                accept;
    logic [1:0]          sel_op;
    logic [1:0]          sel_inv;
    logic [NrOfBits-1:0] sel_a;
    logic [NrOfBits-1:0] sel_b;
    logic [NrOfBits-1:0] op_res;

    // The owner draining its result frees the buffer for a same-cycle refill.
    assign owner_rdy = owner_q ? Rsp1_Ready : Rsp0_Ready;
    assign issue_ok  = (state_q == ST_IDLE) || owner_rdy;
    assign any_vld   = Req0_Valid | Req1_Valid;
    assign grant1    = Req1_Valid & (~Req0_Valid | rr_ptr_q);
    assign accept    = any_vld & issue_ok;

    assign Req0_Ready = Req0_Valid & ~grant1 & issue_ok;
    assign Req1_Ready = Req1_Valid &  grant1 & issue_ok;

    assign sel_op  = grant1 ? Req1_Op  : Req0_Op;
    assign sel_inv = grant1 ? Req1_Inv : Req0_Inv;
    assign sel_a   = grant1 ? Req1_A   : Req0_A;
    assign sel_b   = grant1 ? Req1_B   : Req0_B;

    logic_op_core #(.NrOfBits(NrOfBits)) u_core (
        .inv (sel_inv),
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (op_res)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        if (accept) begin
            state_d  = ST_HOLD;
            owner_d  = grant1;
            rr_ptr_d = ~grant1;
            data_d   = op_res;
        end else if (state_q == ST_HOLD && owner_rdy) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
        end
    end

    assign Rsp0_Valid = (state_q == ST_HOLD) & ~owner_q;
    assign Rsp1_Valid = (state_q == ST_HOLD) &  owner_q;
    assign Rsp_Data   = data_q;

`ifdef LOGIC_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] grant0_cnt_q, grant0_cnt_d;
    logic [PERF_CNT_W-1:0] grant1_cnt_q, grant1_cnt_d;
    logic [PERF_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

    always_comb begin
        grant0_cnt_d = grant0_cnt_q;
        grant1_cnt_d = grant1_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (Req0_Ready)           grant0_cnt_d = sat_inc(grant0_cnt_q);
        if (Req1_Ready)           grant1_cnt_d = sat_inc(grant1_cnt_q);
        if (any_vld && !accept)   stall_cnt_d  = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            grant0_cnt_q <= grant0_cnt_d;
            grant1_cnt_q <= grant1_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign Grant0_Cnt = grant0_cnt_q;
    assign Grant1_Cnt = grant1_cnt_q;
    assign Stall_Cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter; perf counters exercised when LOGIC_ARB_PERF_EN is defined.
module tb_logic_unit_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req0_Valid, Req1_Valid;
    logic        Req0_Ready, Req1_Ready;
    logic [1:0]  Req0_Op, Req1_Op, Req0_Inv, Req1_Inv;
    logic [31:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic        Rsp0_Valid, Rsp1_Valid, Rsp0_Ready, Rsp1_Ready;
    logic [31:0] Rsp_Data;
`ifdef LOGIC_ARB_PERF_EN
    logic [15:0] Grant0_Cnt, Grant1_Cnt, Stall_Cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 Clock = ~Clock;

    logic_unit_arbiter #(.NrOfBits(32)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Req0_Valid (Req0_Valid),
        .Req0_Ready (Req0_Ready),
        .Req0_Op    (Req0_Op),
        .Req0_Inv   (Req0_Inv),
        .Req0_A     (Req0_A),
        .Req0_B     (Req0_B),
        .Req1_Valid (Req1_Valid),
        .Req1_Ready (Req1_Ready),
        .Req1_Op    (Req1_Op),
        .Req1_Inv   (Req1_Inv),
        .Req1_A     (Req1_A),
        .Req1_B     (Req1_B),
        .Rsp0_Valid (Rsp0_Valid),
        .Rsp0_Ready (Rsp0_Ready),
        .Rsp1_Valid (Rsp1_Valid),
        .Rsp1_Ready (Rsp1_Ready),
`ifdef LOGIC_ARB_PERF_EN
        .Grant0_Cnt (Grant0_Cnt),
        .Grant1_Cnt (Grant1_Cnt),
        .Stall_Cnt  (Stall_Cnt),
`endif
        .Rsp_Data   (Rsp_Data)
    );

    // Inputs change 1 time unit after the rising edge; checks land 1 unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [1:0] op, input logic [1:0] inv,
                            input logic [31:0] a, input logic [31:0] b);
        Req0_Valid = v; Req0_Op = op; Req0_Inv = inv; Req0_A = a; Req0_B = b;
    endtask

    task automatic set_req1(input logic v, input logic [1:0] op, input logic [1:0] inv,
                            input logic [31:0] a, input logic [31:0] b);
        Req1_Valid = v; Req1_Op = op; Req1_Inv = inv; Req1_A = a; Req1_B = b;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        Rsp0_Ready = 1'b0;
        Rsp1_Ready = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        Rsp0_Ready = 1'b0;
        Rsp1_Ready = 1'b0;
        #3;
        chk_cnt++;
        if ({Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid} !== 4'b0000 || Rsp_Data !== 32'h0)
            $display("FAIL reset_state: rdy=%b%b vld=%b%b data=%h required all 0",
                     Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
        tick();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req0(1'b1, 2'b00, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        #1;
        chk_cnt++;
        if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0)
            $display("FAIL single_ready: rdy0=%b rdy1=%b required 1 0", Req0_Ready, Req1_Ready);
        else pass_cnt++;
        tick();
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk_cnt++;
        if (Rsp0_Valid !== 1'b1 || Rsp1_Valid !== 1'b0 || Rsp_Data !== 32'hF000F000)
            $display("FAIL single_rsp: vld=%b%b data=%h required 1 0 f000f000",
                     Rsp0_Valid, Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (Rsp0_Valid !== 1'b1 || Rsp_Data !== 32'hF000F000)
            $display("FAIL single_hold: vld0=%b data=%h required 1 f000f000", Rsp0_Valid, Rsp_Data);
        else pass_cnt++;
        Rsp0_Ready = 1'b1;
        tick();
        Rsp0_Ready = 1'b0;
        chk_cnt++;
        if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0)
            $display("FAIL single_drain: vld=%b%b required 00", Rsp0_Valid, Rsp1_Valid);
        else pass_cnt++;
    endtask

    task automatic test_inversion();
        set_req1(1'b1, 2'b01, 2'b11, 32'h0, 32'hFFFFFFFF);
        #1;
        chk_cnt++;
        if (Req1_Ready !== 1'b1 || Req0_Ready !== 1'b0)
            $display("FAIL inv_ready: rdy0=%b rdy1=%b required 0 1", Req0_Ready, Req1_Ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (Rsp1_Valid !== 1'b1 || Rsp0_Valid !== 1'b0 || Rsp_Data !== 32'hFFFFFFFF)
            $display("FAIL inv_or: vld=%b%b data=%h required 0 1 ffffffff",
                     Rsp0_Valid, Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
        // NOR issued in the same cycle the OR result is drained.
        set_req1(1'b1, 2'b11, 2'b00, 32'h0, 32'h0);
        Rsp1_Ready = 1'b1;
        #1;
        chk_cnt++;
        if (Req1_Ready !== 1'b1)
            $display("FAIL nor_refill_ready: rdy1=%b required 1", Req1_Ready);
        else pass_cnt++;
        tick();
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk_cnt++;
        if (Rsp1_Valid !== 1'b1 || Rsp_Data !== 32'hFFFFFFFF)
            $display("FAIL inv_nor: vld1=%b data=%h required 1 ffffffff", Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
        tick();
        Rsp1_Ready = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] exp_d;
        do_reset();
        set_req0(1'b1, 2'b00, 2'b00, 32'hFFFF0000, 32'hFF00FF00);
        set_req1(1'b1, 2'b10, 2'b00, 32'hFFFF0000, 32'hFF00FF00);
        Rsp0_Ready = 1'b1;
        Rsp1_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_cnt++;
            if (Req0_Ready !== (i % 2 == 0) || Req1_Ready !== (i % 2 == 1))
                $display("FAIL contention_grant[%0d]: rdy0=%b rdy1=%b required %b %b",
                         i, Req0_Ready, Req1_Ready, (i % 2 == 0), (i % 2 == 1));
            else pass_cnt++;
            tick();
            exp_d = (i % 2 == 0) ? 32'hFF000000 : 32'h00FFFF00;
            chk_cnt++;
            if (Rsp0_Valid !== (i % 2 == 0) || Rsp1_Valid !== (i % 2 == 1) || Rsp_Data !== exp_d)
                $display("FAIL contention_rsp[%0d]: vld=%b%b data=%h required %b%b %h",
                         i, Rsp0_Valid, Rsp1_Valid, Rsp_Data, (i % 2 == 0), (i % 2 == 1), exp_d);
            else pass_cnt++;
        end
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        Rsp0_Ready = 1'b0;
        Rsp1_Ready = 1'b0;
        chk_cnt++;
        if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0)
            $display("FAIL contention_drain: vld=%b%b required 00", Rsp0_Valid, Rsp1_Valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        set_req0(1'b1, 2'b01, 2'b00, 32'h12340000, 32'h00005678);
        tick();
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        set_req1(1'b1, 2'b10, 2'b00, 32'hAAAA5555, 32'h0F0F0F0F);
        Rsp1_Ready = 1'b1;  // non-owner ready must be ignored
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_cnt++;
            if (Req1_Ready !== 1'b0 || Rsp0_Valid !== 1'b1 || Rsp_Data !== 32'h12345678)
                $display("FAIL bp_stall[%0d]: rdy1=%b vld0=%b data=%h required 0 1 12345678",
                         i, Req1_Ready, Rsp0_Valid, Rsp_Data);
            else pass_cnt++;
            tick();
        end
        Rsp1_Ready = 1'b0;
        Rsp0_Ready = 1'b1;
        #1;
        chk_cnt++;
        if (Req1_Ready !== 1'b1)
            $display("FAIL bp_release_ready: rdy1=%b required 1", Req1_Ready);
        else pass_cnt++;
        tick();
        Rsp0_Ready = 1'b0;
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk_cnt++;
        if (Rsp1_Valid !== 1'b1 || Rsp0_Valid !== 1'b0 || Rsp_Data !== 32'hA5A55A5A)
            $display("FAIL bp_release_rsp: vld=%b%b data=%h required 0 1 a5a55a5a",
                     Rsp0_Valid, Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Drain Req1's result while issuing Req0: leaves HOLD owned by 0 with rr_ptr=1.
        Rsp1_Ready = 1'b1;
        set_req0(1'b1, 2'b00, 2'b00, 32'hCAFEBABE, 32'hFFFFFFFF);
        tick();
        Rsp1_Ready = 1'b0;
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk_cnt++;
        if (Rsp0_Valid !== 1'b1 || Rsp_Data !== 32'hCAFEBABE)
            $display("FAIL mid_pre: vld0=%b data=%h required 1 cafebabe", Rsp0_Valid, Rsp_Data);
        else pass_cnt++;
        #2;
        Reset_n = 1'b0;
        #1;
        chk_cnt++;
        if (Rsp0_Valid !== 1'b0 || Rsp1_Valid !== 1'b0 || Rsp_Data !== 32'h0)
            $display("FAIL mid_reset: vld=%b%b data=%h required 00 0", Rsp0_Valid, Rsp1_Valid, Rsp_Data);
        else pass_cnt++;
        tick();
        Reset_n = 1'b1;
        tick();
        set_req0(1'b1, 2'b00, 2'b00, 32'h1, 32'h1);
        set_req1(1'b1, 2'b00, 2'b00, 32'h2, 32'h2);
        #1;
        chk_cnt++;
        if (Req0_Ready !== 1'b1 || Req1_Ready !== 1'b0)
            $display("FAIL mid_rrptr: rdy0=%b rdy1=%b required 1 0", Req0_Ready, Req1_Ready);
        else pass_cnt++;
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        set_req1(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
    endtask

`ifdef LOGIC_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        set_req0(1'b1, 2'b00, 2'b00, 32'h1, 32'h1);
        Rsp0_Ready = 1'b1;
        for (int i = 0; i < 70000; i++) @(posedge Clock);
        #1;
        set_req0(1'b0, 2'b00, 2'b00, 32'h0, 32'h0);
        chk_cnt++;
        if (Grant0_Cnt !== 16'hFFFF || Grant1_Cnt !== 16'h0 || Stall_Cnt !== 16'h0)
            $display("FAIL perf_cnt: g0=%h g1=%h stall=%h required ffff 0000 0000",
                     Grant0_Cnt, Grant1_Cnt, Stall_Cnt);
        else pass_cnt++;
        tick();
        Rsp0_Ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_inversion();
        test_contention();
        test_backpressure();
        test_reset_mid();
`ifdef LOGIC_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
